wb_port_arbiter: RTL

- Shares the single register-file write port between the in-order pipeline writeback (wb_stage output) and a multi-cycle unit (MUL/DIV) that completes out of band.
- Pipeline writes have priority. MDU results are queued in a small FIFO and drained into idle writeback slots.
- A starvation guard forces a one-cycle pipeline stall when a queued result has waited too long.
- Sits between wb_stage / MDU and the register file write port.

---
 rtl/wb_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results queue in a FIFO
// and drain into idle slots, with a starvation guard. Optional macro WB_ARB_BYPASS_EN sends MDU results straight through when nothing is queued.
module wb_port_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_WAIT   = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  input  logic [4:0]                wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      mdu_valid,
  input  logic [4:0]                mdu_rd,
  input  logic [DATA_WIDTH-1:0]     mdu_data,
  output logic                      mdu_ready,
  output logic                      stall_pipe,
  output logic                      rf_we,
  output logic [4:0]                rf_rd,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [4:0]            mem_rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;

  logic                  rf_we_q, rf_we_d;
  logic [4:0]            rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic empty;
  logic slot_busy;
  logic pop;
  logic bypass;
  logic push_store;

  assign empty      = (count_q == '0);
  assign mdu_ready  = (count_q != CW'(DEPTH));
  assign stall_pipe = !empty && (wait_q >= WW'(MAX_WAIT));

  // A stalled pipeline slot is treated as idle so the starved head always wins that cycle.
  assign slot_busy = wb_valid && (wb_rd != 5'd0) && !stall_pipe;
  assign pop       = !slot_busy && !empty;

`ifdef WB_ARB_BYPASS_EN
  assign bypass = empty && !slot_busy && mdu_valid && (mdu_rd != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Writes to x0 complete the handshake but never occupy a FIFO entry.
  assign push_store = mdu_valid && mdu_ready && (mdu_rd != 5'd0) && !bypass;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (slot_busy) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = wb_rd;
      rf_wdata_d = wb_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = mem_rd_q[rd_ptr_q];
      rf_wdata_d = mem_data_q[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = mdu_rd;
      rf_wdata_d = mdu_data;
    end
  end

  always_comb begin
    wr_ptr_d = push_store ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_store, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Saturates at MAX_WAIT; a starved head pops on the very cycle it reaches the limit.
  always_comb begin
    wait_d = wait_q;
    if (empty || pop) begin
      wait_d = '0;
    end else if (wait_q < WW'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_store) begin
      mem_rd_q[wr_ptr_q]   <= mdu_rd;
      mem_data_q[wr_ptr_q] <= mdu_data;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign fifo_count = count_q;

endmodule
